// File: rtl/visitor_counter_ctrl.sv
// Visitor counter: two beam sensors are synchronized and debounced, a direction
// FSM turns complete beam-break sequences into entry/exit events, a saturating
// 4-digit BCD occupancy counter follows the events, and a scan driver walks the
// digits for a multiplexed display with leading-zero blanking.
module visitor_counter_ctrl #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned SCAN_DIV   = 16,
  parameter int unsigned CAPACITY   = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sen_a,
  input  logic        sen_b,
  output logic [15:0] count_bcd,
  output logic        evt_in,
  output logic        evt_out,
  output logic        full,
  output logic        empty,
  output logic [1:0]  dig_sel,
  output logic        dig_en,
  output logic [3:0]  seg_bcd
);

  // Decimal encoding of the occupancy limit, resolved at elaboration.
  function automatic logic [15:0] toBcd(input int unsigned v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Four-digit decimal increment; a digit at 9 wraps to 0 and carries on.
  function automatic logic [15:0] bcdInc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (carry) begin
        if (v[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Four-digit decimal decrement; a digit at 0 wraps to 9 and borrows on.
  function automatic logic [15:0] bcdDec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (borrow) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [15:0] CAP_BCD   = toBcd(CAPACITY);
  localparam logic [7:0]  DEB_LAST  = 8'(DEB_CYCLES - 1);
  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  typedef enum logic [2:0] {IDLE, A1, AB, B1, BA, JAM} state_t;

  logic [1:0]  meta_q, sync_q;
  logic [1:0]  debLvl;
  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] presc_q;
  logic [1:0]  sel_q;
  logic        a, b;

  // Two-flop synchronizer for both sensors (bit 0 = outer a, bit 1 = inner b).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= {sen_b, sen_a};
      sync_q <= meta_q;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic [7:0] cnt_q;
    logic       lvl_q;

    // Accept a new level only after it has differed for DEB_CYCLES straight cycles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= 8'd0;
        lvl_q <= 1'b0;
      end else if (sync_q[i] == lvl_q) begin
        cnt_q <= 8'd0;
      end else if (cnt_q == DEB_LAST) begin
        cnt_q <= 8'd0;
        lvl_q <= sync_q[i];
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end

    assign debLvl[i] = lvl_q;
  end

  assign a = debLvl[0];
  assign b = debLvl[1];

  // Direction FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and event pulses, issued in the cycle a completed passage leaves AB/BA.
  always_comb begin
    state_d = state_q;
    evt_in  = 1'b0;
    evt_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (a && !b)      state_d = A1;
        else if (!a && b) state_d = B1;
        else if (a && b)  state_d = JAM;
      end
      A1: begin
        if (b)       state_d = AB;
        else if (!a) state_d = IDLE;
      end
      AB: begin
        if (!a && !b) begin
          state_d = IDLE;
          evt_in  = 1'b1;
        end
      end
      B1: begin
        if (a)       state_d = BA;
        else if (!b) state_d = IDLE;
      end
      BA: begin
        if (!a && !b) begin
          state_d = IDLE;
          evt_out = 1'b1;
        end
      end
      JAM: begin
        if (!a && !b) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating occupancy update driven by this cycle's event pulse.
  always_comb begin
    count_d = count_q;
    if (evt_in && !full)        count_d = bcdInc(count_q);
    else if (evt_out && !empty) count_d = bcdDec(count_q);
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 16'h0000;
    else        count_q <= count_d;
  end

  // Scan prescaler; the digit index steps once per SCAN_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= 16'd0;
      sel_q   <= 2'd0;
    end else if (presc_q == SCAN_LAST) begin
      presc_q <= 16'd0;
      sel_q   <= sel_q + 2'd1;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  // Blank a digit when it and every higher digit are zero; units always shown.
  always_comb begin
    dig_en = 1'b1;
    case (sel_q)
      2'd1:    dig_en = |count_q[15:4];
      2'd2:    dig_en = |count_q[15:8];
      2'd3:    dig_en = |count_q[15:12];
      default: dig_en = 1'b1;
    endcase
  end

  assign count_bcd = count_q;
  assign full      = (count_q == CAP_BCD);
  assign empty     = (count_q == 16'h0000);
  assign dig_sel   = sel_q;
  assign seg_bcd   = count_q[4*sel_q +: 4];

endmodule

// File: tb/tb_visitor_counter_ctrl.sv
// Bench for visitor_counter_ctrl: directed passages plus random sensor
// sequences, compared against a passage-level occupancy model. A second
// instance with a capacity of 3 shares the sensors to exercise saturation.
module tb_visitor_counter_ctrl;

  localparam int DEB  = 4;
  localparam int SCAN = 4;
  localparam int CAP  = 9999;
  localparam int CAP3 = 3;

  logic        clk;
  logic        rst_n;
  logic        sen_a;
  logic        sen_b;
  logic [15:0] countBcd, capCountBcd;
  logic        evtIn, evtOut, capEvtIn, capEvtOut;
  logic        full, empty, capFull, capEmpty;
  logic [1:0]  digSel, capDigSel;
  logic        digEn, capDigEn;
  logic [3:0]  segBcd, capSegBcd;

  int checks = 0;
  int errors = 0;

  int modelCount = 0;
  int capCount   = 0;
  int expIn      = 0;
  int expOut     = 0;
  int inSeen     = 0;
  int outSeen    = 0;
  int bothSeen   = 0;
  int cyc        = 0;

  bit       active = 0;
  bit [1:0] first  = 2'b00;
  bit       sawA   = 0;
  bit       sawB   = 0;

  visitor_counter_ctrl #(.DEB_CYCLES(DEB), .SCAN_DIV(SCAN), .CAPACITY(CAP)) dut (
    .clk(clk), .rst_n(rst_n), .sen_a(sen_a), .sen_b(sen_b),
    .count_bcd(countBcd), .evt_in(evtIn), .evt_out(evtOut),
    .full(full), .empty(empty), .dig_sel(digSel), .dig_en(digEn), .seg_bcd(segBcd)
  );

  visitor_counter_ctrl #(.DEB_CYCLES(DEB), .SCAN_DIV(SCAN), .CAPACITY(CAP3)) dutCap (
    .clk(clk), .rst_n(rst_n), .sen_a(sen_a), .sen_b(sen_b),
    .count_bcd(capCountBcd), .evt_in(capEvtIn), .evt_out(capEvtOut),
    .full(capFull), .empty(capEmpty), .dig_sel(capDigSel), .dig_en(capDigEn),
    .seg_bcd(capSegBcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges seen out of reset; the display position follows from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Tally event pulse cycles from the main instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (evtIn)           inSeen++;
      if (evtOut)          outSeen++;
      if (evtIn && evtOut) bothSeen++;
    end
  end

  function automatic logic [15:0] toBcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Passage bookkeeping: a passage starts at the first non-idle level pair and
  // ends on both-clear; outer-first with any inner break is an entry,
  // inner-first with any outer break is an exit, simultaneous start counts nothing.
  task automatic modelLevels(input bit a, input bit b);
    if (!a && !b) begin
      if (active) begin
        if (first == 2'b10 && sawB) begin
          expIn++;
          if (modelCount < CAP)  modelCount++;
          if (capCount   < CAP3) capCount++;
        end else if (first == 2'b01 && sawA) begin
          expOut++;
          if (modelCount > 0) modelCount--;
          if (capCount   > 0) capCount--;
        end
      end
      active = 0;
    end else begin
      if (!active) begin
        active = 1;
        first  = {a, b};
        sawA   = 0;
        sawB   = 0;
      end
      sawA = sawA | a;
      sawB = sawB | b;
    end
  endtask

  // Drive a sensor level pair for a number of cycles, optionally with a
  // two-cycle glitch on one sensor (1 = a, 2 = b) after the level has settled.
  task automatic applyStimulus(input bit a, input bit b, input int hold, input int glitch);
    modelLevels(a, b);
    sen_a = a;
    sen_b = b;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (glitch != 0 && i == 8) begin
        if (glitch == 1) sen_a = ~a;
        else             sen_b = ~b;
      end
      if (i == 10) begin
        sen_a = a;
        sen_b = b;
      end
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".count"},  32'(countBcd),    32'h0);
    checkOutput({tag, ".evtIn"},  32'(evtIn),       32'h0);
    checkOutput({tag, ".evtOut"}, 32'(evtOut),      32'h0);
    checkOutput({tag, ".empty"},  32'(empty),       32'h1);
    checkOutput({tag, ".full"},   32'(full),        32'h0);
    checkOutput({tag, ".digSel"}, 32'(digSel),      32'h0);
    checkOutput({tag, ".digEn"},  32'(digEn),       32'h1);
    checkOutput({tag, ".seg"},    32'(segBcd),      32'h0);
    checkOutput({tag, ".capCnt"}, 32'(capCountBcd), 32'h0);
  endtask

  task automatic verifyState(input string tag);
    int p10[4];
    int sel;
    p10 = '{1, 10, 100, 1000};
    checkOutput({tag, ".count"},    32'(countBcd),    32'(toBcd(modelCount)));
    checkOutput({tag, ".empty"},    32'(empty),       32'(modelCount == 0));
    checkOutput({tag, ".full"},     32'(full),        32'(modelCount == CAP));
    checkOutput({tag, ".capCount"}, 32'(capCountBcd), 32'(toBcd(capCount)));
    checkOutput({tag, ".capFull"},  32'(capFull),     32'(capCount == CAP3));
    checkOutput({tag, ".capEmpty"}, 32'(capEmpty),    32'(capCount == 0));
    checkOutput({tag, ".evtIn"},    32'(inSeen),      32'(expIn));
    checkOutput({tag, ".evtOut"},   32'(outSeen),     32'(expOut));
    checkOutput({tag, ".both"},     32'(bothSeen),    32'h0);
    for (int i = 0; i < 4 * SCAN; i++) begin
      @(negedge clk);
      sel = (cyc / SCAN) % 4;
      checkOutput({tag, ".digSel"}, 32'(digSel), 32'(sel));
      checkOutput({tag, ".seg"},    32'(segBcd), 32'((modelCount / p10[sel]) % 10));
      checkOutput({tag, ".digEn"},  32'(digEn),  32'(sel == 0 || modelCount >= p10[sel]));
    end
  endtask

  initial begin
    int n;
    int lv;
    int g;
    rst_n = 1'b0;
    sen_a = 1'b0;
    sen_b = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    verifyState("idle");

    $display("[TB] single entry");
    applyStimulus(1, 0, 10, 0);
    applyStimulus(1, 1, 10, 0);
    applyStimulus(0, 1, 10, 0);
    applyStimulus(0, 0, 12, 0);
    verifyState("entry");

    $display("[TB] exit back to zero, then exit while empty");
    applyStimulus(0, 1, 10, 0);
    applyStimulus(1, 1, 10, 0);
    applyStimulus(1, 0, 10, 0);
    applyStimulus(0, 0, 12, 0);
    verifyState("exit");
    applyStimulus(0, 1, 10, 0);
    applyStimulus(1, 1, 10, 0);
    applyStimulus(0, 0, 12, 0);
    verifyState("exitEmpty");

    $display("[TB] aborted passage with glitches, jam");
    applyStimulus(1, 0, 16, 2);
    applyStimulus(0, 0, 16, 2);
    verifyState("abort");
    applyStimulus(1, 1, 10, 0);
    applyStimulus(0, 1, 10, 0);
    applyStimulus(0, 0, 12, 0);
    verifyState("jam");

    $display("[TB] fill past small capacity, ramp to 100, step down");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 8, 0);
      applyStimulus(1, 1, 8, 0);
      applyStimulus(0, 1, 8, 0);
      applyStimulus(0, 0, 10, 0);
    end
    verifyState("cap");
    for (int k = 0; k < 96; k++) begin
      applyStimulus(1, 0, 8, 0);
      applyStimulus(1, 1, 8, 0);
      applyStimulus(0, 1, 8, 0);
      applyStimulus(0, 0, 10, 0);
      if (k == 37) verifyState("c42");
    end
    verifyState("c100");
    applyStimulus(0, 1, 10, 0);
    applyStimulus(1, 1, 10, 0);
    applyStimulus(1, 0, 10, 0);
    applyStimulus(0, 0, 12, 0);
    verifyState("c99");

    $display("[TB] random passages");
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        lv = $urandom_range(1, 3);
        g  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        applyStimulus(lv[1], lv[0], (g != 0) ? 16 : $urandom_range(8, 14), g);
      end
      applyStimulus(0, 0, 12, 0);
      verifyState("rand");
    end

    $display("[TB] reset in the middle of a passage");
    applyStimulus(1, 0, 10, 0);
    applyStimulus(1, 1, 10, 0);
    rst_n = 1'b0;
    #1;
    checkReset("midReset");
    active     = 0;
    modelCount = 0;
    capCount   = 0;
    repeat (2) @(negedge clk);
    sen_b = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1, 0, 10, 0);
    applyStimulus(0, 0, 12, 0);
    verifyState("afterReset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
